// File: rtl/fp_matmul_pkg.sv
// Shared types and helpers for the sequential fixed-point matrix multiplier.
// The requantise function is also used by the softmax block.
package fp_matmul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      EMIT
   } state_t;

   function automatic int acc_width(input int in_w, input int col_1);
      return 2 * in_w + $clog2(col_1) + 1;
   endfunction

   function automatic int requant_shift(input int in_frac, input int out_frac);
      return 2 * in_frac - out_frac;
   endfunction

   // Round half up, then clamp to the signed out_w range.
   function automatic longint requantise(input longint acc, input int sh, input int out_w);
      longint v;
      longint hi;
      longint lo;
      v = acc;
      if (sh > 0) begin
         v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
      end
      hi = (longint'(1) <<< (out_w - 1)) - 1;
      lo = -(longint'(1) <<< (out_w - 1));
      if (v > hi) begin
         v = hi;
      end else if (v < lo) begin
         v = lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/fp_mac_lane.sv
// One signed multiply-accumulate lane. acc_next exposes the sum being
// written this cycle so the final value can be requantised without a bubble.
module fp_mac_lane #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 35
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [IN_W-1:0]  a,
   input  logic signed [IN_W-1:0]  b,
   output logic signed [ACC_W-1:0] acc_next
);

   logic signed [2*IN_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc;

   assign prod     = a * b;
   assign acc_next = acc + ACC_W'(prod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/fp_matmul_seq.sv
// Sequential fixed-point C = A x B, LANES output columns per group, with
// start/busy/done handshake and valid/ready output backpressure.
module fp_matmul_seq
   import fp_matmul_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int IN_FRAC  = 8,
   parameter int OUT_W    = 16,
   parameter int OUT_FRAC = 8,
   parameter int ROW_1    = 8,
   parameter int COL_1    = 4,
   parameter int COL_2    = 8,
   parameter int LANES    = 2,
   parameter int ACC_W    = acc_width(IN_W, COL_1),
   localparam int ROW_W   = (ROW_1 > 1) ? $clog2(ROW_1) : 1,
   localparam int COL_W   = (COL_2 > 1) ? $clog2(COL_2) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ROW_1*COL_1*IN_W-1:0] mat_in1,
   input  logic [COL_1*COL_2*IN_W-1:0] mat_in2,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   out_data,
   output logic [ROW_W-1:0]         out_row,
   output logic [COL_W-1:0]         out_col,
   output logic                     done
);

   localparam int K_W = (COL_1 > 1) ? $clog2(COL_1) : 1;
   localparam int SH  = requant_shift(IN_FRAC, OUT_FRAC);

   state_t                         state;
   logic [ROW_1*COL_1*IN_W-1:0]    a_reg;
   logic [COL_1*COL_2*IN_W-1:0]    b_reg;
   logic [ROW_W-1:0]               row;
   logic [COL_W-1:0]               col;
   logic [K_W-1:0]                 k;

   logic signed [IN_W-1:0]         a_elem;
   logic signed [IN_W-1:0]         b_elem   [LANES];
   logic signed [ACC_W-1:0]        acc_next [LANES];
   longint                         rq       [LANES];
   logic [LANES*OUT_W-1:0]         requant_bus;
   logic                           lane_clr;
   logic                           lane_en;

   assign lane_clr = (state != MAC);
   assign lane_en  = (state == MAC);

   // Every lane shares A[row][k] and takes its own column of B.
   always_comb begin
      a_elem = a_reg[(int'(row) * COL_1 + int'(k)) * IN_W +: IN_W];
      for (int l = 0; l < LANES; l++) begin
         b_elem[l] = b_reg[(int'(k) * COL_2 + int'(col) + l) * IN_W +: IN_W];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fp_mac_lane #(
         .IN_W  (IN_W),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (lane_clr),
         .en       (lane_en),
         .a        (a_elem),
         .b        (b_elem[g]),
         .acc_next (acc_next[g])
      );
   end

   always_comb begin
      requant_bus = '0;
      for (int l = 0; l < LANES; l++) begin
         rq[l] = requantise(longint'(acc_next[l]), SH, OUT_W);
         requant_bus[l*OUT_W +: OUT_W] = rq[l][OUT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         row       <= '0;
         col       <= '0;
         k         <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= mat_in1;
                  b_reg <= mat_in2;
                  row   <= '0;
                  col   <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               if (k == K_W'(COL_1 - 1)) begin
                  out_data  <= requant_bus;
                  out_row   <= row;
                  out_col   <= col;
                  out_valid <= 1'b1;
                  state     <= EMIT;
               end else begin
                  k <= k + 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  k         <= '0;
                  out_valid <= 1'b0;
                  if (int'(col) + LANES < COL_2) begin
                     col   <= col + COL_W'(LANES);
                     state <= MAC;
                  end else if (int'(row) < ROW_1 - 1) begin
                     row   <= row + 1'b1;
                     col   <= '0;
                     state <= MAC;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_matmul_seq.sv
// Scoreboard bench for fp_matmul_seq: a reference model queues expected
// groups on each start and a negedge monitor pops and compares them.
module tb_fp_matmul_seq;

   localparam int IN_W     = 16;
   localparam int IN_FRAC  = 8;
   localparam int OUT_W    = 16;
   localparam int OUT_FRAC = 8;
   localparam int ROW_1    = 8;
   localparam int COL_1    = 4;
   localparam int COL_2    = 8;
   localparam int LANES    = 2;
   localparam int ROW_W    = $clog2(ROW_1);
   localparam int COL_W    = $clog2(COL_2);
   localparam int SH       = 2 * IN_FRAC - OUT_FRAC;
   localparam longint OMAX = (longint'(1) << (OUT_W - 1)) - 1;
   localparam longint OMIN = -(longint'(1) << (OUT_W - 1));
   localparam int FULL_LAT = ROW_1 * (COL_2 / LANES) * (COL_1 + 1);

   logic                           clk = 1'b0;
   logic                           rst_n;
   logic                           start;
   logic [ROW_1*COL_1*IN_W-1:0]    mat_in1;
   logic [COL_1*COL_2*IN_W-1:0]    mat_in2;
   logic                           busy;
   logic                           out_valid;
   logic                           out_ready;
   logic [LANES*OUT_W-1:0]         out_data;
   logic [ROW_W-1:0]               out_row;
   logic [COL_W-1:0]               out_col;
   logic                           done;

   fp_matmul_seq #(
      .IN_W     (IN_W),
      .IN_FRAC  (IN_FRAC),
      .OUT_W    (OUT_W),
      .OUT_FRAC (OUT_FRAC),
      .ROW_1    (ROW_1),
      .COL_1    (COL_1),
      .COL_2    (COL_2),
      .LANES    (LANES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mat_in1   (mat_in1),
      .mat_in2   (mat_in2),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                     row;
      int                     col;
      logic [LANES*OUT_W-1:0] data;
   } grp_t;

   grp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   start_cyc = 0;

   logic signed [IN_W-1:0] ma [ROW_1][COL_1];
   logic signed [IN_W-1:0] mb [COL_1][COL_2];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Round half up to OUT_FRAC bits, then clamp into the output range.
   function automatic longint refRequant(input longint sum);
      longint v;
      v = sum;
      if (SH > 0) v = (sum + (longint'(1) << (SH - 1))) >>> SH;
      if (v > OMAX) v = OMAX;
      if (v < OMIN) v = OMIN;
      return v;
   endfunction

   task automatic buildExpected();
      grp_t   g;
      longint s;
      longint q;
      for (int r = 0; r < ROW_1; r++) begin
         for (int c = 0; c < COL_2; c += LANES) begin
            g.row  = r;
            g.col  = c;
            g.data = '0;
            for (int l = 0; l < LANES; l++) begin
               s = 0;
               for (int kk = 0; kk < COL_1; kk++) begin
                  s += longint'(ma[r][kk]) * longint'(mb[kk][c+l]);
               end
               q = refRequant(s);
               g.data[l*OUT_W +: OUT_W] = q[OUT_W-1:0];
            end
            sb.push_back(g);
         end
      end
   endtask

   // mode: 0 identity-like, 1 random, 2 +max saturate, 3 -max saturate, 4 rounding edge
   task automatic applyStimulus(input int mode);
      for (int r = 0; r < ROW_1; r++) begin
         for (int kk = 0; kk < COL_1; kk++) begin
            case (mode)
               0: ma[r][kk] = (kk == r % COL_1) ? 16'sh0100 : 16'sh0000;
               1: begin
                  ma[r][kk] = 16'($urandom);
                  if ($urandom_range(0, 2) != 0) ma[r][kk] = ma[r][kk] >>> 5;
               end
               2: ma[r][kk] = 16'sh7FFF;
               3: ma[r][kk] = 16'sh8000;
               default: ma[r][kk] = (kk == 0) ? 16'sh0001 : 16'sh0000;
            endcase
         end
      end
      for (int kk = 0; kk < COL_1; kk++) begin
         for (int c = 0; c < COL_2; c++) begin
            case (mode)
               0: mb[kk][c] = 16'((kk * COL_2 + c) << 8);
               1: begin
                  mb[kk][c] = 16'($urandom);
                  if ($urandom_range(0, 2) != 0) mb[kk][c] = mb[kk][c] >>> 5;
               end
               2, 3: mb[kk][c] = 16'sh7FFF;
               default: mb[kk][c] = (kk != 0) ? 16'sh0000 : ((c % 2 == 0) ? 16'sh0080 : 16'sh007F);
            endcase
         end
      end
      for (int r = 0; r < ROW_1; r++)
         for (int kk = 0; kk < COL_1; kk++)
            mat_in1[(r*COL_1+kk)*IN_W +: IN_W] = ma[r][kk];
      for (int kk = 0; kk < COL_1; kk++)
         for (int c = 0; c < COL_2; c++)
            mat_in2[(kk*COL_2+c)*IN_W +: IN_W] = mb[kk][c];
      buildExpected();
   endtask

   task automatic issueStart();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      start_cyc = cyc;
      checkOutput("busy_after_start", 64'(busy), 64'd1);
   endtask

   // Ends on the negedge where done is seen high.
   task automatic waitDone(input bit check_latency);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("done_seen", 64'(seen), 64'd1);
      if (seen) begin
         if (check_latency) checkOutput("start_to_done", 64'(cyc - start_cyc), 64'(FULL_LAT));
         checkOutput("busy_at_done", 64'(busy), 64'd0);
         checkOutput("groups_left", 64'(sb.size()), 64'd0);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_data"}, 64'(out_data), 64'd0);
      checkOutput({tag, "_row"}, 64'(out_row), 64'd0);
      checkOutput({tag, "_col"}, 64'(out_col), 64'd0);
   endtask

   // Monitor: stall stability and scoreboard comparison on each handshake.
   logic                   pv = 1'b0;
   logic                   pr = 1'b0;
   logic [LANES*OUT_W-1:0] pd;
   logic [ROW_W-1:0]       prow;
   logic [COL_W-1:0]       pcol;

   always @(negedge clk) begin
      grp_t e;
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_data", 64'(out_data), 64'(pd));
            checkOutput("hold_row", 64'(out_row), 64'(prow));
            checkOutput("hold_col", 64'(out_col), 64'(pcol));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_group", 64'(out_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("group_row", 64'(out_row), 64'(e.row));
               checkOutput("group_col", 64'(out_col), 64'(e.col));
               checkOutput("group_data", 64'(out_data), 64'(e.data));
            end
         end
         pv   = out_valid;
         pr   = out_ready;
         pd   = out_data;
         prow = out_row;
         pcol = out_col;
      end
   end

   initial begin
      bit seen;
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      mat_in1   = '0;
      mat_in2   = '0;
      repeat (3) @(posedge clk);
      #1 checkResetOutputs("reset");
      rst_n = 1'b1;

      $display("[TB] identity, saturation and rounding runs");
      for (int m = 0; m < 5; m++) begin
         if (m == 1) continue;
         applyStimulus(m);
         issueStart();
         waitDone(1'b1);
         @(negedge clk);
         checkOutput("done_pulse", 64'(done), 64'd0);
      end

      $display("[TB] back-to-back random runs with start on done");
      applyStimulus(1);
      issueStart();
      waitDone(1'b1);
      applyStimulus(1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      start_cyc = cyc;
      checkOutput("busy_b2b", 64'(busy), 64'd1);
      waitDone(1'b1);

      $display("[TB] backpressure and start while busy");
      applyStimulus(1);
      issueStart();
      seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (i >= 20 && i < 25) out_ready = 1'b0;
         else if (i >= 25) out_ready = ($urandom_range(0, 3) != 0);
         else out_ready = 1'b1;
         if (i == 10) begin
            start   = 1'b1;
            mat_in1 = ~mat_in1;
            mat_in2 = ~mat_in2;
         end
         if (i == 11) start = 1'b0;
      end
      checkOutput("bp_done_seen", 64'(seen), 64'd1);
      checkOutput("bp_groups_left", 64'(sb.size()), 64'd0);
      checkOutput("bp_busy_at_done", 64'(busy), 64'd0);
      out_ready = 1'b1;

      $display("[TB] reset mid-operation then restart");
      applyStimulus(1);
      issueStart();
      repeat (19) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 checkResetOutputs("midreset");
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(1);
      issueStart();
      waitDone(1'b1);
      @(negedge clk);
      checkOutput("restart_done_pulse", 64'(done), 64'd0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
